// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types, widths and helpers for the pipeline controller
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_MEM_DONE = 2'd2,
        ST_UNUSED   = 2'd3
    } state_t;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 16;
    localparam int TMO_W  = 8;
    localparam logic [TMO_W-1:0] TIMEOUT_MAX = 8'd255;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - load-use hazard comparator between ID/EX and IF/ID
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic              idex_memread_i,
    input  logic [REG_AW-1:0] idex_rt_i,
    input  logic [REG_AW-1:0] ifid_rs_i,
    input  logic [REG_AW-1:0] ifid_rt_i,
    output logic              hazard_o
);

    logic w_rt_nonzero;
    logic w_match;

    // r0 is hardwired to zero, so a load targeting it never creates a dependency
    assign w_rt_nonzero = (idex_rt_i != '0);
    assign w_match      = (idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i);
    assign hazard_o     = idex_memread_i && w_rt_nonzero && w_match;

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - memory-stall FSM, hazard/flush priority and stall statistics
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              IDEX_MemRead_i,
    input  logic [REG_AW-1:0] IDEX_RegRt_i,
    input  logic [REG_AW-1:0] IFID_RegRs_i,
    input  logic [REG_AW-1:0] IFID_RegRt_i,
    input  logic              branch_taken_i,
    input  logic              jump_i,
    input  logic              EXMEM_MemRead_i,
    input  logic              EXMEM_MemWrite_i,
    input  logic              mem_ack_i,
    output logic              mem_req_o,
    output logic              mem_rdata_en_o,
    output logic              stall_all_o,
    output logic              stall_front_o,
    output logic              IDEX_bubble_o,
    output logic              IFID_flush_o,
    output logic              err_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [1:0]        state_o
);

    state_t             r_state;
    state_t             w_next;
    state_t             w_state_eff;
    logic [TMO_W-1:0]   r_tmo;
    logic               r_err;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic               w_memop;
    logic               w_hazard;
    logic               w_stall_all;

    assign w_memop = EXMEM_MemRead_i | EXMEM_MemWrite_i;

    // While reset is held the combinational outputs behave as if already in IDLE
    assign w_state_eff = rst_i ? ST_IDLE : r_state;

    hazard_detect u_hazard_detect (
        .idex_memread_i (IDEX_MemRead_i),
        .idex_rt_i      (IDEX_RegRt_i),
        .ifid_rs_i      (IFID_RegRs_i),
        .ifid_rt_i      (IFID_RegRt_i),
        .hazard_o       (w_hazard)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = ST_IDLE;
        case (r_state)
            ST_IDLE: begin
                if (w_memop) begin
                    w_next = mem_ack_i ? ST_MEM_DONE : ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                w_next = mem_ack_i ? ST_MEM_DONE : ST_MEM_WAIT;
            end
            ST_MEM_DONE: w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
    end

    // MEM_DONE deliberately drops the request so the finished access advances exactly once
    always_comb begin
        w_stall_all = 1'b0;
        case (w_state_eff)
            ST_IDLE:     w_stall_all = w_memop;
            ST_MEM_WAIT: w_stall_all = 1'b1;
            default:     w_stall_all = 1'b0;
        endcase
        mem_req_o      = w_stall_all;
        stall_all_o    = w_stall_all;
        mem_rdata_en_o = mem_ack_i & w_stall_all & EXMEM_MemRead_i;
        stall_front_o  = w_hazard & ~w_stall_all;
        IDEX_bubble_o  = w_hazard & ~w_stall_all;
        IFID_flush_o   = (branch_taken_i | jump_i) & ~w_stall_all & ~w_hazard;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tmo       <= '0;
            r_err       <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            if (w_stall_all) begin
                r_stall_cnt <= sat_inc(r_stall_cnt);
            end
            if (r_state == ST_IDLE && w_next == ST_MEM_WAIT) begin
                r_tmo <= '0;
            end else if (r_state == ST_MEM_WAIT && !mem_ack_i) begin
                // Timeout is only reported; the access keeps waiting for its ack
                if (r_tmo == TIMEOUT_MAX) begin
                    r_err <= 1'b1;
                end else begin
                    r_tmo <= r_tmo + 8'd1;
                end
            end
        end
    end

    assign err_o       = r_err;
    assign stall_cnt_o = r_stall_cnt;
    assign state_o     = r_state;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        idex_memread;
    logic [4:0]  idex_rt;
    logic [4:0]  ifid_rs;
    logic [4:0]  ifid_rt;
    logic        branch;
    logic        jump;
    logic        ex_rd;
    logic        ex_wr;
    logic        ack;
    logic        mem_req;
    logic        rdata_en;
    logic        stall_all;
    logic        stall_front;
    logic        bubble;
    logic        flush;
    logic        err;
    logic [15:0] stall_cnt;
    logic [1:0]  state;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .IDEX_MemRead_i   (idex_memread),
        .IDEX_RegRt_i     (idex_rt),
        .IFID_RegRs_i     (ifid_rs),
        .IFID_RegRt_i     (ifid_rt),
        .branch_taken_i   (branch),
        .jump_i           (jump),
        .EXMEM_MemRead_i  (ex_rd),
        .EXMEM_MemWrite_i (ex_wr),
        .mem_ack_i        (ack),
        .mem_req_o        (mem_req),
        .mem_rdata_en_o   (rdata_en),
        .stall_all_o      (stall_all),
        .stall_front_o    (stall_front),
        .IDEX_bubble_o    (bubble),
        .IFID_flush_o     (flush),
        .err_o            (err),
        .stall_cnt_o      (stall_cnt),
        .state_o          (state)
    );

    task automatic clear_inputs();
        idex_memread = 1'b0; idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
        branch = 1'b0; jump = 1'b0; ex_rd = 1'b0; ex_wr = 1'b0; ack = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        ex_rd = 1'b1;
        #1;
        n_tests++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rst_comb_req got=%b exp=1", mem_req); end
        tick(); tick();
        n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL rst_state got=%0d exp=0", state); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err got=%b exp=0", err); end
        n_tests++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_cnt got=%0d exp=0", stall_cnt); end
        ex_rd = 1'b0;
        rst = 1'b0;
        #1;
        n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_idle_req got=%b exp=0", mem_req); end
        n_tests++; if (stall_all !== 1'b0) begin n_fail++; $display("FAIL rst_idle_stall got=%b exp=0", stall_all); end
    endtask

    task automatic test_load_ack3();
        do_reset();
        ex_rd = 1'b1;
        #1;
        n_tests++; if ({mem_req, stall_all, rdata_en} !== 3'b110) begin n_fail++; $display("FAIL ld_c1 got=%b exp=110", {mem_req, stall_all, rdata_en}); end
        tick();
        n_tests++; if (state !== 2'd1 || mem_req !== 1'b1) begin n_fail++; $display("FAIL ld_c2 state=%0d req=%b exp=1,1", state, mem_req); end
        tick();
        ack = 1'b1;
        #1;
        n_tests++; if ({state, stall_all, rdata_en} !== 4'b0111) begin n_fail++; $display("FAIL ld_c3 got=%b exp=0111", {state, stall_all, rdata_en}); end
        tick();
        n_tests++; if ({state, mem_req, stall_all, rdata_en} !== 5'b10000) begin n_fail++; $display("FAIL ld_done got=%b exp=10000", {state, mem_req, stall_all, rdata_en}); end
        n_tests++; if (stall_cnt !== 16'd3) begin n_fail++; $display("FAIL ld_cnt got=%0d exp=3", stall_cnt); end
        ex_rd = 1'b0; ack = 1'b0;
        tick();
        n_tests++; if (state !== 2'd0 || stall_cnt !== 16'd3) begin n_fail++; $display("FAIL ld_idle state=%0d cnt=%0d exp=0,3", state, stall_cnt); end
    endtask

    task automatic test_store_ack1();
        do_reset();
        ex_wr = 1'b1; ack = 1'b1;
        #1;
        n_tests++; if ({mem_req, stall_all, rdata_en} !== 3'b110) begin n_fail++; $display("FAIL st_c1 got=%b exp=110", {mem_req, stall_all, rdata_en}); end
        tick();
        n_tests++; if (state !== 2'd2 || stall_all !== 1'b0) begin n_fail++; $display("FAIL st_done state=%0d stall=%b exp=2,0", state, stall_all); end
        ex_wr = 1'b0; ack = 1'b0;
        tick();
        n_tests++; if (state !== 2'd0 || stall_cnt !== 16'd1) begin n_fail++; $display("FAIL st_idle state=%0d cnt=%0d exp=0,1", state, stall_cnt); end
    endtask

    task automatic test_load_use();
        do_reset();
        idex_memread = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5; ifid_rt = 5'd7;
        #1;
        n_tests++; if ({stall_front, bubble, flush, stall_all} !== 4'b1100) begin n_fail++; $display("FAIL lu_rs got=%b exp=1100", {stall_front, bubble, flush, stall_all}); end
        ifid_rs = 5'd3; ifid_rt = 5'd5;
        #1;
        n_tests++; if ({stall_front, bubble} !== 2'b11) begin n_fail++; $display("FAIL lu_rt got=%b exp=11", {stall_front, bubble}); end
        idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
        #1;
        n_tests++; if ({stall_front, bubble} !== 2'b00) begin n_fail++; $display("FAIL lu_r0 got=%b exp=00", {stall_front, bubble}); end
        idex_memread = 1'b0; idex_rt = 5'd5; ifid_rs = 5'd5;
        #1;
        n_tests++; if (stall_front !== 1'b0) begin n_fail++; $display("FAIL lu_noload got=%b exp=0", stall_front); end
        branch = 1'b1;
        #1;
        n_tests++; if (flush !== 1'b1) begin n_fail++; $display("FAIL br_flush got=%b exp=1", flush); end
        branch = 1'b0; jump = 1'b1;
        #1;
        n_tests++; if (flush !== 1'b1) begin n_fail++; $display("FAIL jmp_flush got=%b exp=1", flush); end
        jump = 1'b0; branch = 1'b1; idex_memread = 1'b1;
        #1;
        n_tests++; if ({stall_front, flush} !== 2'b10) begin n_fail++; $display("FAIL lu_over_br got=%b exp=10", {stall_front, flush}); end
        clear_inputs();
        #1;
    endtask

    task automatic test_priority();
        do_reset();
        idex_memread = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5; branch = 1'b1;
        ex_rd = 1'b1; ack = 1'b1;
        #1;
        n_tests++; if ({stall_all, stall_front, bubble, flush} !== 4'b1000) begin n_fail++; $display("FAIL pri_mem got=%b exp=1000", {stall_all, stall_front, bubble, flush}); end
        tick();
        n_tests++; if ({state, stall_all, stall_front, bubble, flush} !== 6'b100110) begin n_fail++; $display("FAIL pri_done got=%b exp=100110", {state, stall_all, stall_front, bubble, flush}); end
        ex_rd = 1'b0; ack = 1'b0;
        tick();
        n_tests++; if ({state, stall_front, flush} !== 4'b0010) begin n_fail++; $display("FAIL pri_idle got=%b exp=0010", {state, stall_front, flush}); end
        idex_memread = 1'b0;
        #1;
        n_tests++; if (flush !== 1'b1) begin n_fail++; $display("FAIL pri_flush got=%b exp=1", flush); end
        clear_inputs();
        #1;
    endtask

    task automatic test_timeout();
        do_reset();
        ex_rd = 1'b1;
        repeat (256) tick();
        n_tests++; if (state !== 2'd1 || err !== 1'b0) begin n_fail++; $display("FAIL tmo_before state=%0d err=%b exp=1,0", state, err); end
        tick();
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL tmo_set got=%b exp=1", err); end
        repeat (5) tick();
        n_tests++; if (err !== 1'b1 || state !== 2'd1) begin n_fail++; $display("FAIL tmo_hold err=%b state=%0d exp=1,1", err, state); end
        n_tests++; if (stall_cnt !== 16'd262) begin n_fail++; $display("FAIL tmo_cnt got=%0d exp=262", stall_cnt); end
        ack = 1'b1;
        #1;
        n_tests++; if (rdata_en !== 1'b1) begin n_fail++; $display("FAIL tmo_ack_en got=%b exp=1", rdata_en); end
        tick();
        n_tests++; if (state !== 2'd2 || err !== 1'b1) begin n_fail++; $display("FAIL tmo_done state=%0d err=%b exp=2,1", state, err); end
        ex_rd = 1'b0; ack = 1'b0;
        tick();
        n_tests++; if (state !== 2'd0 || err !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky state=%0d err=%b exp=0,1", state, err); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_tests++; if (err !== 1'b0 || stall_cnt !== 16'd0) begin n_fail++; $display("FAIL tmo_rst err=%b cnt=%0d exp=0,0", err, stall_cnt); end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        ex_rd = 1'b1;
        tick(); tick();
        n_tests++; if (state !== 2'd1) begin n_fail++; $display("FAIL rmw_wait got=%0d exp=1", state); end
        rst = 1'b1; ex_rd = 1'b0;
        #1;
        n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rmw_comb got=%b exp=0", mem_req); end
        tick();
        rst = 1'b0;
        #1;
        n_tests++; if (state !== 2'd0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL rmw_after state=%0d req=%b exp=0,0", state, mem_req); end
        tick();
        n_tests++; if (state !== 2'd0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL rmw_next state=%0d req=%b exp=0,0", state, mem_req); end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_load_ack3();
        test_store_ack1();
        test_load_use();
        test_priority();
        test_timeout();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 clk_i  in  1  single clock; all state updates on rising edge.
REQ-002 rst_i  in  1  reset, synchronous, active-high.
REQ-003 IDEX_MemRead_i  in  1  instruction in ID/EX is a load.
REQ-004 IDEX_RegRt_i  in  5  load destination register in ID/EX.
REQ-005 IFID_RegRs_i, IFID_RegRt_i  in  5 each  source registers of the instruction in IF/ID.
REQ-006 branch_taken_i  in  1  branch resolved taken in ID.
REQ-007 jump_i  in  1  jump decoded in ID.
REQ-008 EXMEM_MemRead_i, EXMEM_MemWrite_i  in  1 each  memory operation present in EX/MEM.
REQ-009 mem_ack_i  in  1  data memory completes the current access this cycle.
REQ-010 mem_req_o  out  1  data memory access request.
REQ-011 mem_rdata_en_o  out  1  capture enable for the read-data holding register.
REQ-012 stall_all_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
REQ-013 stall_front_o  out  1  freeze PC and IF/ID only.
REQ-014 IDEX_bubble_o  out  1  zero the ID/EX control fields on the next edge.
REQ-015 IFID_flush_o  out  1  zero IF/ID on the next edge.
REQ-016 err_o  out  1  sticky memory-timeout flag.
REQ-017 stall_cnt_o  out  16  count of memory-stall cycles.
REQ-018 state_o  out  2  current FSM state, for debug.

Function
REQ-019 FSM states: IDLE=0, MEM_WAIT=1, MEM_DONE=2; encoding 3 unused, recovers to IDLE on the next edge.
REQ-020 Define memop = EXMEM_MemRead_i | EXMEM_MemWrite_i.
REQ-021 mem_req_o = stall_all_o = (IDLE & memop) | MEM_WAIT, combinational, so the pipeline freezes in the same cycle the access starts.
REQ-022 IDLE & memop & ~mem_ack_i -> MEM_WAIT; IDLE & memop & mem_ack_i -> MEM_DONE; MEM_WAIT & mem_ack_i -> MEM_DONE; MEM_DONE -> IDLE unconditionally.
REQ-023 In MEM_DONE, mem_req_o=0 and stall_all_o=0, giving exactly one advance cycle so the completed access cannot retrigger.
REQ-024 mem_rdata_en_o = mem_ack_i & mem_req_o & EXMEM_MemRead_i; mem_ack_i is ignored whenever mem_req_o=0.
REQ-025 Load-use hazard: IDEX_MemRead_i & (IDEX_RegRt_i != 0) & (IDEX_RegRt_i == IFID_RegRs_i | IDEX_RegRt_i == IFID_RegRt_i).
REQ-026 Load-use hazard with stall_all_o=0: stall_front_o=1 and IDEX_bubble_o=1 for that cycle only.
REQ-027 Taken branch or jump, with stall_all_o=0 and no load-use hazard: IFID_flush_o=1.
REQ-028 Priority is stall_all_o > load-use > flush; a lower-priority output is 0 while a higher one is active.
REQ-029 An 8-bit timeout counter loads 0 on entry to MEM_WAIT and increments each MEM_WAIT cycle.
REQ-030 Counter = 255 with mem_ack_i=0 sets err_o=1; err_o stays 1 until reset; the FSM keeps waiting and the counter holds at 255.
REQ-031 stall_cnt_o increments each cycle stall_all_o=1 and saturates at 65535.

Reset
REQ-032 rst_i=1 at an edge sets state to IDLE, timeout counter to 0, stall_cnt_o to 0 and err_o to 0.
REQ-033 Reset applies from any state; if asserted in MEM_WAIT, mem_req_o=0 from the following cycle unless memop is still present after reset release.
REQ-034 Combinational outputs follow REQ-021 to REQ-028 from the IDLE state while rst_i=1.

Structure
REQ-035 Shared package pipe_ctrl_pkg holds the state encoding, TIMEOUT_MAX=255 and the widths REG_AW=5 and CNT_W=16.
REQ-036 Load-use comparison is the sub-module hazard_detect (combinational); the FSM, counters and priority logic stay in pipe_ctrl.

Verification
REQ-037 Load in EX/MEM, ack on 3rd cycle of request -> stall_all_o and mem_req_o high 3 cycles, mem_rdata_en_o on 3rd cycle, then MEM_DONE 1 cycle, then IDLE; stall_cnt_o=3.
REQ-038 Store in EX/MEM with ack in the first request cycle -> 1 stall cycle, mem_rdata_en_o=0, state IDLE->MEM_DONE->IDLE.
REQ-039 IDEX load rt=5 with IFID rs=5 -> stall_front_o=1 and IDEX_bubble_o=1 for one cycle; repeat with rt=0 -> no stall.
REQ-040 Load-use hazard, branch_taken_i and memop in the same cycle -> only stall_all_o=1; after MEM_DONE the load-use stall is asserted and the flush is deferred.
REQ-041 No ack for 256 cycles -> err_o=1 and stays 1; later ack -> MEM_DONE; rst_i -> err_o=0, stall_cnt_o=0.
REQ-042 rst_i asserted mid-MEM_WAIT with memop=0 after release -> state_o=0, mem_req_o=0 on the next cycle.
